// File: rtl/apb_requester_pkg.sv
// Shared types and helpers for the APB requester: FSM state encoding,
// width helpers and the packed response record.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_e;

  // Widest supported data bus; the response record is sized for it.
  localparam int MAX_DATA_WIDTH = 32;

  // Number of byte strobes for a given data width.
  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

  // Number of low address bits that must be zero for an aligned access.
  function automatic int align_bits(input int dw);
    return (dw == 8) ? 0 : ((dw == 16) ? 1 : 2);
  endfunction

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_requester_if.sv
// Bundle of the command/response stream and the APB bus of the requester.
// master: the requester side; slave: the command source plus completers.
interface apb_requester_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLV    = 4
);
  localparam int STRB_W = strb_width(DATA_WIDTH);

  // command stream
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [ADDR_WIDTH-1:0]         cmd_addr;
  logic [DATA_WIDTH-1:0]         cmd_wdata;
  logic [STRB_W-1:0]             cmd_strb;
  // response stream
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          rsp_timeout;
  // APB bus
  logic [NUM_SLV-1:0]            psel;
  logic                          penable;
  logic                          pwrite;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [STRB_W-1:0]             pstrb;
  logic [NUM_SLV-1:0]            pready;
  logic [NUM_SLV*DATA_WIDTH-1:0] prdata;
  logic [NUM_SLV-1:0]            pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata, pstrb
  );

endinterface

// File: rtl/apb_requester_addr_decode.sv
// Combinational address decode: region index -> one-hot completer select,
// out-of-range detection and data-width alignment check.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_SLV      = 4,
  parameter int REGION_SHIFT = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLV-1:0]    sel_o,
  output logic                  decode_err_o,
  output logic                  misaligned_o
);
  localparam int ALIGN = align_bits(DATA_WIDTH);

  // Region index kept at full address width so out-of-range upper bits
  // are never silently truncated into a valid index.
  logic [ADDR_WIDTH-1:0] idx;

  assign idx          = addr_i >> REGION_SHIFT;
  assign decode_err_o = (idx >= ADDR_WIDTH'(NUM_SLV));

  // One-hot select; all zero when the index is out of range.
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
    assign sel_o[gi] = (idx == ADDR_WIDTH'(gi));
  end

  // Byte-wide buses can never be misaligned.
  if (ALIGN > 0) begin : g_align
    assign misaligned_o = |addr_i[ALIGN-1:0];
  end else begin : g_no_align
    assign misaligned_o = 1'b0;
  end

endmodule

// File: rtl/apb_requester.sv
// APB requester: converts a valid/ready command stream into single APB
// transfers (one outstanding), with decode/alignment errors answered
// locally and a bounded wait for pready.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_SLV      = 4,
  parameter int REGION_SHIFT = 12,
  parameter int TIMEOUT      = 16
) (
  input logic              pclk,
  input logic              preset,
  apb_requester_if.master  bus
);
  localparam int STRB_W = strb_width(DATA_WIDTH);

  apb_req_state_e        state_q, state_d;
  logic [NUM_SLV-1:0]    sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  apb_rsp_t              rsp_q, rsp_d;

  logic [NUM_SLV-1:0]    dec_sel;
  logic                  dec_err;
  logic                  dec_misaligned;

  apb_addr_decode #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_SLV      (NUM_SLV),
    .REGION_SHIFT (REGION_SHIFT)
  ) u_decode (
    .addr_i       (bus.cmd_addr),
    .sel_o        (dec_sel),
    .decode_err_o (dec_err),
    .misaligned_o (dec_misaligned)
  );

  // Per-completer read data gated by the registered select, so only the
  // addressed completer can contribute.
  logic [DATA_WIDTH-1:0] prdata_masked [NUM_SLV];
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_rd_mask
    assign prdata_masked[gi] = sel_q[gi] ? bus.prdata[gi*DATA_WIDTH +: DATA_WIDTH]
                                         : '0;
  end

  logic                  sel_pready;
  logic                  sel_pslverr;
  logic [DATA_WIDTH-1:0] sel_prdata;

  // Reduce the selected completer's return signals to scalars.
  always_comb begin
    sel_pready  = |(bus.pready & sel_q);
    sel_pslverr = |(bus.pslverr & sel_q);
    sel_prdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_prdata = sel_prdata | prdata_masked[i];
    end
  end

  // Next-state and datapath updates for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    wait_cnt_d = wait_cnt_q;
    rsp_d      = rsp_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (dec_err || dec_misaligned) begin
            // Answer locally; the APB bus is never touched.
            rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b0};
            state_d = RESP;
          end else begin
            sel_d    = dec_sel;
            paddr_d  = bus.cmd_addr;
            pwrite_d = bus.cmd_write;
            pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
            state_d  = SETUP;
          end
        end
      end
      SETUP: begin
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (sel_pready) begin
          // Read data only reported for successful reads.
          rsp_d.rdata   = (pwrite_q || sel_pslverr) ? '0 : MAX_DATA_WIDTH'(sel_prdata);
          rsp_d.err     = sel_pslverr;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          // Abort: the counter has now reached TIMEOUT waiting cycles.
          rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      wait_cnt_q <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_q      <= rsp_d;
    end
  end

  logic in_xfer;
  assign in_xfer = (state_q == SETUP) || (state_q == ACCESS);

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = in_xfer ? sel_q : '0;
  assign bus.penable     = (state_q == ACCESS);
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Directed testbench for apb_requester: one task per scenario, each with
// hand-computed expectations checked inline.
module tb_apb_requester;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic pclk = 1'b0;
  logic preset;
  int   n_cmp = 0;
  int   n_err = 0;

  apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS)) bus();

  apb_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS), .REGION_SHIFT(12), .TIMEOUT(16)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (2) cyc();
    n_cmp++; if ({bus.psel, bus.penable, bus.pwrite} !== 6'b0) begin n_err++; $display("FAIL rst_sel_en_wr: got %b want %b", {bus.psel, bus.penable, bus.pwrite}, 6'b0); end
    n_cmp++; if ({bus.paddr, bus.pwdata, bus.pstrb} !== 68'h0) begin n_err++; $display("FAIL rst_addr_data_strb: got %h want %h", {bus.paddr, bus.pwdata, bus.pstrb}, 68'h0); end
    n_cmp++; if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== 35'h0) begin n_err++; $display("FAIL rst_rsp: got %h want %h", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, 35'h0); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
    preset = 1'b0;
    cyc();
    $display("txn reset done");
  endtask

  task automatic test_read_zero_wait();
    bus.pready  = 4'b0001;
    bus.pslverr = 4'b1110;
    bus.prdata  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    issue(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rd_cmd_ready: got %b want 1", bus.cmd_ready); end
    cyc();  // cycle 1: SETUP
    bus.cmd_valid = 1'b0;
    n_cmp++; if ({bus.psel, bus.penable} !== 5'b0001_0) begin n_err++; $display("FAIL rd_setup_sel: got %b want %b", {bus.psel, bus.penable}, 5'b00010); end
    n_cmp++; if ({bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb} !== {32'h4, 1'b0, 32'h0, 4'h0}) begin n_err++; $display("FAIL rd_setup_bus: got %h want %h", {bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb}, {32'h4, 1'b0, 32'h0, 4'h0}); end
    n_cmp++; if ({bus.cmd_ready, bus.rsp_valid} !== 2'b00) begin n_err++; $display("FAIL rd_setup_hs: got %b want 00", {bus.cmd_ready, bus.rsp_valid}); end
    cyc();  // cycle 2: ACCESS
    n_cmp++; if ({bus.psel, bus.penable} !== 5'b0001_1) begin n_err++; $display("FAIL rd_access_sel: got %b want %b", {bus.psel, bus.penable}, 5'b00011); end
    cyc();  // cycle 3: RESP
    n_cmp++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 6'b0000_0_1) begin n_err++; $display("FAIL rd_resp_ctl: got %b want %b", {bus.psel, bus.penable, bus.rsp_valid}, 6'b000001); end
    n_cmp++; if ({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {32'hDEAD_BEEF, 2'b00}) begin n_err++; $display("FAIL rd_resp_data: got %h want %h", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, {32'hDEAD_BEEF, 2'b00}); end
    bus.pready  = 4'b0;
    bus.pslverr = 4'b0;
    cyc();  // handshake done
    n_cmp++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin n_err++; $display("FAIL rd_idle: got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
    $display("txn read addr=00000004 rdata=%h err=%b", 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_write_waits();
    bus.prdata = {32'h0, 32'h0, 32'h5555_AAAA, 32'h0};
    issue(1'b1, 32'h0000_1008, 32'h1234_5678, 4'b0011);
    cyc();  // cycle 1: SETUP
    bus.cmd_valid = 1'b0;
    n_cmp++; if ({bus.psel, bus.penable} !== 5'b0010_0) begin n_err++; $display("FAIL wr_setup_sel: got %b want %b", {bus.psel, bus.penable}, 5'b00100); end
    n_cmp++; if ({bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb} !== {32'h1008, 1'b1, 32'h1234_5678, 4'b0011}) begin n_err++; $display("FAIL wr_setup_bus: got %h want %h", {bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb}, {32'h1008, 1'b1, 32'h1234_5678, 4'b0011}); end
    for (int i = 0; i < 4; i++) begin
      cyc();  // ACCESS cycles 2..5
      n_cmp++; if ({bus.psel, bus.penable} !== 5'b0010_1) begin n_err++; $display("FAIL wr_access_sel[%0d]: got %b want %b", i, {bus.psel, bus.penable}, 5'b00101); end
      n_cmp++; if ({bus.paddr, bus.pwdata, bus.pstrb} !== {32'h1008, 32'h1234_5678, 4'b0011}) begin n_err++; $display("FAIL wr_access_bus[%0d]: got %h want %h", i, {bus.paddr, bus.pwdata, bus.pstrb}, {32'h1008, 32'h1234_5678, 4'b0011}); end
      if (i == 3) bus.pready = 4'b0010;
      else        bus.pready = 4'b1101;  // other completers ready: must be ignored
    end
    cyc();  // cycle 6: RESP
    bus.pready = 4'b0;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {1'b1, 32'h0, 2'b00}) begin n_err++; $display("FAIL wr_resp: got %h want %h", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, {1'b1, 32'h0, 2'b00}); end
    n_cmp++; if (bus.psel !== 4'b0) begin n_err++; $display("FAIL wr_resp_psel: got %b want 0000", bus.psel); end
    cyc();
    $display("txn write addr=00001008 wdata=12345678 strb=0011 waits=3");
  endtask

  task automatic test_errors();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_0003;
    addrs[1] = 32'h0000_5000;
    bus.pready = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      issue(i[0], addrs[i], 32'hA5A5_A5A5, 4'hF);
      cyc();  // cycle 1: RESP directly
      bus.cmd_valid = 1'b0;
      n_cmp++; if ({bus.psel, bus.penable} !== 5'b0) begin n_err++; $display("FAIL err%0d_psel: got %b want 00000", i, {bus.psel, bus.penable}); end
      n_cmp++; if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {1'b1, 32'h0, 2'b10}) begin n_err++; $display("FAIL err%0d_rsp: got %h want %h", i, {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, {1'b1, 32'h0, 2'b10}); end
      cyc();
      n_cmp++; if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 6'b01_0000) begin n_err++; $display("FAIL err%0d_idle: got %b want 010000", i, {bus.rsp_valid, bus.cmd_ready, bus.psel}); end
      n_cmp++; if (bus.paddr !== 32'h0000_1008) begin n_err++; $display("FAIL err%0d_paddr_hold: got %h want 00001008", i, bus.paddr); end
      $display("txn error addr=%h err=1", addrs[i]);
    end
    bus.pready = 4'b0;
  endtask

  task automatic test_pslverr();
    bus.pready  = 4'b0100;
    bus.pslverr = 4'b0100;
    bus.prdata  = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
    issue(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    cyc();  // SETUP
    bus.cmd_valid = 1'b0;
    n_cmp++; if (bus.psel !== 4'b0100) begin n_err++; $display("FAIL slverr_psel: got %b want 0100", bus.psel); end
    cyc();  // ACCESS
    cyc();  // RESP
    n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b110) begin n_err++; $display("FAIL slverr_rsp: got %b want 110", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}); end
    bus.pready  = 4'b0;
    bus.pslverr = 4'b0;
    cyc();
    $display("txn read addr=00002000 err=1 timeout=0");
  endtask

  task automatic test_timeout();
    bus.pready = 4'b0111;  // every completer but the addressed one
    bus.prdata = {32'h7777_7777, 32'h0, 32'h0, 32'h0};
    issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    cyc();  // SETUP
    bus.cmd_valid = 1'b0;
    n_cmp++; if (bus.psel !== 4'b1000) begin n_err++; $display("FAIL to_setup_psel: got %b want 1000", bus.psel); end
    for (int i = 0; i < 16; i++) begin
      cyc();
      n_cmp++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 6'b1000_1_0) begin n_err++; $display("FAIL to_access[%0d]: got %b want 100010", i, {bus.psel, bus.penable, bus.rsp_valid}); end
    end
    cyc();  // aborted into RESP
    n_cmp++; if ({bus.psel, bus.penable} !== 5'b0) begin n_err++; $display("FAIL to_drop_psel: got %b want 00000", {bus.psel, bus.penable}); end
    n_cmp++; if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {1'b1, 32'h0, 2'b11}) begin n_err++; $display("FAIL to_rsp: got %h want %h", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, {1'b1, 32'h0, 2'b11}); end
    bus.rsp_ready = 1'b0;
    bus.pready    = 4'b1000;  // late ready
    cyc();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.psel} !== {1'b1, 32'h0, 2'b11, 4'b0}) begin n_err++; $display("FAIL to_late_ready: got %h want %h", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.psel}, {1'b1, 32'h0, 2'b11, 4'b0}); end
    bus.pready    = 4'b0;
    bus.rsp_ready = 1'b1;
    cyc();
    n_cmp++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin n_err++; $display("FAIL to_idle: got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
    $display("txn read addr=00003000 err=1 timeout=1");
  endtask

  task automatic test_backpressure_reset();
    bus.pready    = 4'b0001;
    bus.prdata    = {32'h0, 32'h0, 32'h0, 32'h0BAD_CAFE};
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    cyc();  // SETUP
    bus.cmd_valid = 1'b0;
    cyc();  // ACCESS
    cyc();  // RESP
    bus.prdata = {32'h0, 32'h0, 32'h0, 32'h1111_2222};
    bus.pready = 4'b0;
    issue(1'b1, 32'h0000_1000, 32'h0, 4'h0);  // must not be taken while busy
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata, bus.rsp_err} !== {2'b10, 32'h0BAD_CAFE, 1'b0}) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata, bus.rsp_err}, {2'b10, 32'h0BAD_CAFE, 1'b0}); end
      cyc();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    cyc();  // handshake
    n_cmp++; if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 6'b01_0000) begin n_err++; $display("FAIL bp_release: got %b want 010000", {bus.rsp_valid, bus.cmd_ready, bus.psel}); end
    $display("txn read addr=00000000 rdata=0badcafe backpressure=5");
    issue(1'b1, 32'h0000_1000, 32'hFEED_0001, 4'hF);
    cyc();  // SETUP
    bus.cmd_valid = 1'b0;
    cyc();  // ACCESS
    n_cmp++; if ({bus.psel, bus.penable} !== 5'b0010_1) begin n_err++; $display("FAIL rst_pre_access: got %b want 00101", {bus.psel, bus.penable}); end
    preset = 1'b1;
    cyc();
    n_cmp++; if ({bus.psel, bus.penable, bus.pwrite} !== 6'b0) begin n_err++; $display("FAIL rstmid_ctl: got %b want 000000", {bus.psel, bus.penable, bus.pwrite}); end
    n_cmp++; if ({bus.paddr, bus.pwdata, bus.pstrb} !== 68'h0) begin n_err++; $display("FAIL rstmid_bus: got %h want 0", {bus.paddr, bus.pwdata, bus.pstrb}); end
    n_cmp++; if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== 35'h0) begin n_err++; $display("FAIL rstmid_rsp: got %h want 0", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}); end
    preset     = 1'b0;
    bus.pready = 4'b0010;  // stale ready for the dropped transfer
    cyc();
    bus.pready = 4'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 6'b01_0000) begin n_err++; $display("FAIL rstmid_after[%0d]: got %b want 010000", i, {bus.rsp_valid, bus.cmd_ready, bus.psel}); end
      cyc();
    end
    $display("txn write addr=00001000 dropped by reset");
  endtask

  initial begin
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b1;
    bus.pready    = '0;
    bus.prdata    = '0;
    bus.pslverr   = '0;
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_errors();
    test_pslverr();
    test_timeout();
    test_backpressure_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound in case the design stalls the directed sequence.
  initial begin
    #20000;
    $display("FAIL watchdog: got no finish by 20000ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
